// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory access unit built around a MAR/MDR pair, an internal word-addressed
// RAM and a multi-cycle access sequencer with programmable wait states.
// The control unit loads the MAR (and the MDR for writes), pulses req, then
// waits for done.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   mar_sclr   synchronous clear of the MAR (highest MAR priority)
//   mar_en     load mar_d into the MAR
//   mar_inc    increment the MAR (wraps)
//   mar_d      MAR load value
//   mdr_en     load bus_alu into the MDR
//   bus_alu    ALU result bus
//   mdr_alu_n  bus_out select: 1 = MDR, 0 = bus_alu
//   req        start an access (sampled only in IDLE)
//   wr_rdn     access type latched with req: 1 = write, 0 = read
//   mar_q      current MAR
//   mdr_q      current MDR
//   bus_out    combinational mdr_alu_n ? mdr_q : bus_alu
//   busy       high in WAIT and ACCESS
//   done       one-cycle completion pulse
module mem_access_unit #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mar_sclr,
   input  logic                  mar_en,
   input  logic                  mar_inc,
   input  logic [ADDR_WIDTH-1:0] mar_d,
   input  logic                  mdr_en,
   input  logic [DATA_WIDTH-1:0] bus_alu,
   input  logic                  mdr_alu_n,
   input  logic                  req,
   input  logic                  wr_rdn,
   output logic [ADDR_WIDTH-1:0] mar_q,
   output logic [DATA_WIDTH-1:0] mdr_q,
   output logic [DATA_WIDTH-1:0] bus_out,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [ADDR_WIDTH-1:0] MAR_ONE = 1;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  op_wr_q, op_wr_d;
   logic [ADDR_WIDTH-1:0] mar_next_d;
   logic [DATA_WIDTH-1:0] mdr_next_d;
   logic                  ctl_ok;

   // MAR/MDR host controls are honoured only when no access is in flight,
   // which keeps the address and write data frozen during WAIT and ACCESS.
   assign ctl_ok = (state_q == S_IDLE) || (state_q == S_DONE);

   // Sequencer next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               op_wr_d = wr_rdn;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: state_d = S_DONE;
         // A req arriving here is dropped, not queued.
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // MAR next value: sclr > en > inc
   always_comb begin
      mar_next_d = mar_q;
      if (ctl_ok) begin
         if (mar_sclr) begin
            mar_next_d = '0;
         end else if (mar_en) begin
            mar_next_d = mar_d;
         end else if (mar_inc) begin
            mar_next_d = mar_q + MAR_ONE;
         end
      end
   end

   // MDR next value: a read completion always wins over host loads
   always_comb begin
      mdr_next_d = mdr_q;
      if (state_q == S_ACCESS && !op_wr_q) begin
         mdr_next_d = mem[mar_q];
      end else if (ctl_ok && mdr_en) begin
         mdr_next_d = bus_alu;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_wr_q <= 1'b0;
         mar_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         mar_q   <= mar_next_d;
         mdr_q   <= mdr_next_d;
      end
   end

   // RAM is not cleared by reset, but a reset sampled in ACCESS must
   // suppress the write, hence the rst qualifier.
   always_ff @(posedge clk) begin
      if (rst && state_q == S_ACCESS && op_wr_q) begin
         mem[mar_q] <= mdr_q;
      end
   end

   assign bus_out = mdr_alu_n ? mdr_q : bus_alu;
   assign busy    = (state_q == S_WAIT) || (state_q == S_ACCESS);
   assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int WS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          mar_sclr, mar_en, mar_inc;
   logic [AW-1:0] mar_d;
   logic          mdr_en;
   logic [DW-1:0] bus_alu;
   logic          mdr_alu_n;
   logic          req, wr_rdn;
   logic [AW-1:0] mar_q;
   logic [DW-1:0] mdr_q;
   logic [DW-1:0] bus_out;
   logic          busy, done;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .WAIT_STATES(WS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mar_sclr (mar_sclr),
      .mar_en   (mar_en),
      .mar_inc  (mar_inc),
      .mar_d    (mar_d),
      .mdr_en   (mdr_en),
      .bus_alu  (bus_alu),
      .mdr_alu_n(mdr_alu_n),
      .req      (req),
      .wr_rdn   (wr_rdn),
      .mar_q    (mar_q),
      .mdr_q    (mdr_q),
      .bus_out  (bus_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [DW-1:0] mdr;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic          sclr;
      logic          en;
      logic          inc;
      logic [AW-1:0] d;
      logic [AW-1:0] exp_mar;
   } mar_vec_t;

   typedef struct {
      logic          sel;
      logic [DW-1:0] alu;
      logic [DW-1:0] exp_out;
   } bus_vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_ctl();
      mar_sclr = 1'b0; mar_en = 1'b0; mar_inc = 1'b0; mar_d = '0;
      mdr_en = 1'b0; bus_alu = '0; req = 1'b0; wr_rdn = 1'b0;
   endtask

   task automatic load_mar(input logic [AW-1:0] a);
      mar_en = 1'b1; mar_d = a;
      step();
      mar_en = 1'b0;
   endtask

   task automatic load_mdr(input logic [DW-1:0] v);
      mdr_en = 1'b1; bus_alu = v;
      step();
      mdr_en = 1'b0;
   endtask

   // One full access; expected MDR at the done cycle goes through the scoreboard.
   task automatic do_access(input logic wr, input logic [DW-1:0] exp_mdr);
      exp_t e;
      int   n;
      int   nb;
      e.wr = wr; e.mdr = exp_mdr;
      sb.push_back(e);
      req = 1'b1; wr_rdn = wr;
      step();
      req = 1'b0; wr_rdn = ~wr;
      n = 0; nb = 0;
      while (!done && n < 20) begin
         if (busy) nb++;
         step();
         n++;
      end
      e = sb.pop_front();
      if (!done) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("done_latency", n, WS + 1);
         chk("busy_cycles", nb, WS + 1);
         chk(e.wr ? "wr_mdr_at_done" : "rd_mdr_at_done", int'(mdr_q), int'(e.mdr));
      end
      step();
      chk("idle_after_done", int'({busy, done}), 0);
      wr_rdn = 1'b0;
   endtask

   mar_vec_t mar_tab[8];
   bus_vec_t bus_tab[3];

   initial begin
      int quiet_bad;

      mar_tab[0] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'hF};
      mar_tab[1] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0};
      mar_tab[2] = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h5};
      mar_tab[3] = '{1'b1, 1'b1, 1'b1, 4'hC, 4'h0};
      mar_tab[4] = '{1'b0, 1'b1, 1'b1, 4'h7, 4'h7};
      mar_tab[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h8};
      mar_tab[6] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h8};
      mar_tab[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0};

      bus_tab[0] = '{1'b1, 8'h3E, 8'h5C};
      bus_tab[1] = '{1'b0, 8'h3E, 8'h3E};
      bus_tab[2] = '{1'b0, 8'hA1, 8'hA1};

      // 1. Reset with a competing MAR load
      clear_ctl();
      mdr_alu_n = 1'b1;
      rst = 1'b0;
      mar_en = 1'b1; mar_d = 4'hA;
      step();
      step();
      chk("rst_mar", int'(mar_q), 0);
      chk("rst_mdr", int'(mdr_q), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b1;
      clear_ctl();
      step();

      // 2. Write then read back
      load_mar(4'h3);
      load_mdr(8'h5C);
      chk("setup_mar", int'(mar_q), 3);
      chk("setup_mdr", int'(mdr_q), 8'h5C);
      do_access(1'b1, 8'h5C);
      load_mdr(8'h00);
      chk("mdr_cleared", int'(mdr_q), 0);
      do_access(1'b0, 8'h5C);
      for (int i = 0; i < 3; i++) begin
         mdr_alu_n = bus_tab[i].sel;
         bus_alu   = bus_tab[i].alu;
         #1;
         chk("bus_out", int'(bus_out), int'(bus_tab[i].exp_out));
      end
      bus_alu = '0;
      mdr_alu_n = 1'b1;

      // 3. MAR control table
      for (int i = 0; i < 8; i++) begin
         mar_sclr = mar_tab[i].sclr;
         mar_en   = mar_tab[i].en;
         mar_inc  = mar_tab[i].inc;
         mar_d    = mar_tab[i].d;
         step();
         chk("mar_ctl", int'(mar_q), int'(mar_tab[i].exp_mar));
      end
      clear_ctl();

      // 4. Busy lockout during WAIT/ACCESS, req held through DONE
      load_mar(4'h2);
      load_mdr(8'h42);
      req = 1'b1; wr_rdn = 1'b1;
      step();
      chk("lock_busy", int'(busy), 1);
      mar_en = 1'b1; mar_d = 4'h9; mdr_en = 1'b1; bus_alu = 8'hFF;
      req = 1'b1; wr_rdn = 1'b0;
      step();
      step();
      chk("lock_mar", int'(mar_q), 2);
      chk("lock_mdr", int'(mdr_q), 8'h42);
      chk("lock_busy_access", int'(busy), 1);
      mar_en = 1'b0; mdr_en = 1'b0; bus_alu = '0;
      step();
      chk("lock_done", int'(done), 1);
      chk("lock_mdr_done", int'(mdr_q), 8'h42);
      step();
      req = 1'b0;
      quiet_bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (busy || done) quiet_bad++;
         step();
      end
      chk("lock_no_second_access", quiet_bad, 0);
      load_mdr(8'h00);
      do_access(1'b0, 8'h42);

      // 5. Reset sampled in ACCESS aborts the write
      load_mar(4'h5);
      load_mdr(8'h11);
      do_access(1'b1, 8'h11);
      load_mdr(8'hAA);
      req = 1'b1; wr_rdn = 1'b1;
      step();
      req = 1'b0;
      step();
      step();
      chk("abort_in_access", int'(busy), 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("abort_mar", int'(mar_q), 0);
      chk("abort_mdr", int'(mdr_q), 0);
      chk("abort_busy", int'(busy), 0);
      quiet_bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) quiet_bad++;
         step();
      end
      chk("abort_no_done", quiet_bad, 0);
      load_mar(4'h5);
      do_access(1'b0, 8'h11);

      // 6. Burst write then read back over the whole RAM
      mar_sclr = 1'b1;
      step();
      mar_sclr = 1'b0;
      for (int a = 0; a < 16; a++) begin
         load_mdr(8'(a * 3));
         do_access(1'b1, 8'(a * 3));
         mar_inc = 1'b1;
         step();
         mar_inc = 1'b0;
      end
      chk("burst_wr_mar_wrap", int'(mar_q), 0);
      for (int a = 0; a < 16; a++) begin
         do_access(1'b0, 8'(a * 3));
         mar_inc = 1'b1;
         step();
         mar_inc = 1'b0;
      end
      chk("burst_rd_mar_wrap", int'(mar_q), 0);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
